// File: rtl/host_regfile_pkg.sv
// Shared definitions for the host register file: register offsets, FSM state types and
// bit positions within CTRL and IRQ.
package host_regfile_pkg;

    localparam logic [31:0] REG_CTRL   = 32'h00;
    localparam logic [31:0] REG_CYCLES = 32'h04;
    localparam logic [31:0] REG_LENGTH = 32'h08;
    localparam logic [31:0] REG_INP_LO = 32'h0C;
    localparam logic [31:0] REG_INP_HI = 32'h10;
    localparam logic [31:0] REG_OUT_LO = 32'h14;
    localparam logic [31:0] REG_OUT_HI = 32'h18;
    localparam logic [31:0] REG_IRQ    = 32'h1C;

    localparam int unsigned CTRL_START_BIT  = 0;
    localparam int unsigned CTRL_DONE_BIT   = 1;
    localparam int unsigned IRQ_ENABLE_BIT  = 0;
    localparam int unsigned IRQ_PENDING_BIT = 1;

    typedef enum logic {
        H_IDLE,
        H_READ
    } host_state_t;

    typedef enum logic {
        C_IDLE,
        C_BUSY
    } ctrl_state_t;

endpackage

// File: rtl/host_regfile.sv
// Host-visible control/status register file driving the add-by-one engine.
// Optional interrupt register and irq port are enabled by defining HOST_REGFILE_IRQ_EN.
module host_regfile
    import host_regfile_pkg::*;
#(
    parameter int unsigned HOST_ADDR_BITS = 8,
    parameter int unsigned HOST_DATA_BITS = 32,
    parameter int unsigned MEM_ADDR_BITS  = 64
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      host_req_valid,
    input  logic                      host_req_opcode,
    input  logic [HOST_ADDR_BITS-1:0] host_req_addr,
    input  logic [HOST_DATA_BITS-1:0] host_req_value,
    output logic                      host_req_deq,
    output logic                      host_resp_valid,
    output logic [HOST_DATA_BITS-1:0] host_resp_bits,
    output logic                      launch,
    input  logic                      finish,
    output logic [HOST_DATA_BITS-1:0] length,
    output logic [MEM_ADDR_BITS-1:0]  inp_baddr,
    output logic [MEM_ADDR_BITS-1:0]  out_baddr
`ifdef HOST_REGFILE_IRQ_EN
    ,
    output logic                      irq
`endif
);

    // Base addresses are split into a low host word and the remaining high bits.
    localparam int unsigned HI_BITS = MEM_ADDR_BITS - HOST_DATA_BITS;

    host_state_t host_state_q;
    ctrl_state_t ctrl_state_q;

    logic [HOST_DATA_BITS-1:0] resp_bits_q;
    logic                      resp_valid_q;
    logic                      launch_q;
    logic                      done_q;
    logic [HOST_DATA_BITS-1:0] cycles_q;
    logic [HOST_DATA_BITS-1:0] length_q;
    logic [MEM_ADDR_BITS-1:0]  inp_baddr_q;
    logic [MEM_ADDR_BITS-1:0]  out_baddr_q;

    logic [31:0]               word_addr;
    logic                      wr_acc;
    logic                      rd_acc;
    logic                      start_wr;
    logic                      cfg_wr;
    logic                      busy_finish;
    logic [HOST_DATA_BITS-1:0] rd_data;

    assign word_addr    = 32'(host_req_addr) & ~32'h3;
    assign host_req_deq = (host_state_q == H_IDLE) && host_req_valid;
    assign wr_acc       = host_req_deq && host_req_opcode;
    assign rd_acc       = host_req_deq && !host_req_opcode;
    assign start_wr     = wr_acc && (word_addr == REG_CTRL) && host_req_value[CTRL_START_BIT];
    // Engine configuration is frozen while a run is in flight.
    assign cfg_wr       = wr_acc && (ctrl_state_q == C_IDLE);
    assign busy_finish  = (ctrl_state_q == C_BUSY) && finish;

`ifdef HOST_REGFILE_IRQ_EN
    logic irq_enable_q;
    logic irq_pending_q;
`endif

    always_comb begin
        rd_data = '0;
        case (word_addr)
            REG_CTRL:   rd_data[CTRL_DONE_BIT] = done_q;
            REG_CYCLES: rd_data = cycles_q;
            REG_LENGTH: rd_data = length_q;
            REG_INP_LO: rd_data = inp_baddr_q[HOST_DATA_BITS-1:0];
            REG_INP_HI: rd_data = HOST_DATA_BITS'(inp_baddr_q >> HOST_DATA_BITS);
            REG_OUT_LO: rd_data = out_baddr_q[HOST_DATA_BITS-1:0];
            REG_OUT_HI: rd_data = HOST_DATA_BITS'(out_baddr_q >> HOST_DATA_BITS);
`ifdef HOST_REGFILE_IRQ_EN
            REG_IRQ: begin
                rd_data[IRQ_ENABLE_BIT]  = irq_enable_q;
                rd_data[IRQ_PENDING_BIT] = irq_pending_q;
            end
`endif
            default: rd_data = '0;
        endcase
    end

    // Host FSM: reads capture the pre-edge register view and answer one cycle later.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            host_state_q <= H_IDLE;
            resp_valid_q <= 1'b0;
            resp_bits_q  <= '0;
        end else begin
            resp_valid_q <= 1'b0;
            case (host_state_q)
                H_IDLE: begin
                    if (rd_acc) begin
                        resp_bits_q  <= rd_data;
                        resp_valid_q <= 1'b1;
                        host_state_q <= H_READ;
                    end
                end
                H_READ:  host_state_q <= H_IDLE;
                default: host_state_q <= H_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_state_q <= C_IDLE;
            launch_q     <= 1'b0;
            done_q       <= 1'b0;
            cycles_q     <= '0;
        end else begin
            launch_q <= 1'b0;
            case (ctrl_state_q)
                C_IDLE: begin
                    if (start_wr) begin
                        launch_q     <= 1'b1;
                        done_q       <= 1'b0;
                        cycles_q     <= '0;
                        ctrl_state_q <= C_BUSY;
                    end
                end
                C_BUSY: begin
                    // The finishing cycle is counted as part of the run.
                    if (cycles_q != '1) begin
                        cycles_q <= cycles_q + HOST_DATA_BITS'(1);
                    end
                    if (finish) begin
                        done_q       <= 1'b1;
                        ctrl_state_q <= C_IDLE;
                    end
                end
                default: ctrl_state_q <= C_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            length_q    <= '0;
            inp_baddr_q <= '0;
            out_baddr_q <= '0;
        end else if (cfg_wr) begin
            case (word_addr)
                REG_LENGTH: length_q <= host_req_value;
                REG_INP_LO: inp_baddr_q[HOST_DATA_BITS-1:0] <= host_req_value;
                REG_INP_HI: inp_baddr_q[MEM_ADDR_BITS-1:HOST_DATA_BITS] <=
                                host_req_value[HI_BITS-1:0];
                REG_OUT_LO: out_baddr_q[HOST_DATA_BITS-1:0] <= host_req_value;
                REG_OUT_HI: out_baddr_q[MEM_ADDR_BITS-1:HOST_DATA_BITS] <=
                                host_req_value[HI_BITS-1:0];
                default: ;
            endcase
        end
    end

`ifdef HOST_REGFILE_IRQ_EN
    logic irq_wr;
    assign irq_wr = wr_acc && (word_addr == REG_IRQ);

    // A finish landing in the same cycle as a W1C keeps the interrupt pending.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            irq_enable_q  <= 1'b0;
            irq_pending_q <= 1'b0;
        end else begin
            if (irq_wr) begin
                irq_enable_q <= host_req_value[IRQ_ENABLE_BIT];
            end
            if (busy_finish && irq_enable_q) begin
                irq_pending_q <= 1'b1;
            end else if (irq_wr && host_req_value[IRQ_PENDING_BIT]) begin
                irq_pending_q <= 1'b0;
            end
        end
    end

    assign irq = irq_pending_q;
`else
    logic unused_busy_finish;
    assign unused_busy_finish = busy_finish;
`endif

    assign host_resp_valid = resp_valid_q;
    assign host_resp_bits  = resp_bits_q;
    assign launch          = launch_q;
    assign length          = length_q;
    assign inp_baddr       = inp_baddr_q;
    assign out_baddr       = out_baddr_q;

endmodule
